// File: rtl/cdc_pkg.sv
// Shared types and parameter legality helpers for the clock-domain-crossing input blocks.
package cdc_pkg;

  typedef enum logic {ST_STABLE, ST_CHECK} debounce_state_t;

  function automatic bit debounce_params_ok(input int sync_stages, input int debounce_cycles);
    return (sync_stages >= 2) && (debounce_cycles >= 1);
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// Flop-chain synchronizer plus debounce FSM: turns a raw asynchronous level into a
// stable registered level with single-cycle rise/fall pulses.
module debounce_sync
  import cdc_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 1000,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic signal_async,
  output logic level,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (!debounce_params_ok(SYNC_STAGES, DEBOUNCE_CYCLES)) begin : g_param_check
    $error("debounce_sync: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   differ;
  debounce_state_t        state;
  logic [CNT_W-1:0]       cnt;

  // The chain resets to RESET_LEVEL so synced matches level right out of reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], signal_async};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];
  assign differ = (synced != level);

  // busy mirrors the state register and is the externally visible view of the FSM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_STABLE;
      cnt        <= '0;
      level      <= RESET_LEVEL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      case (state)
        ST_STABLE: begin
          if (differ) begin
            if (DEBOUNCE_CYCLES == 1) begin
              level      <= synced;
              rise_pulse <= synced;
              fall_pulse <= !synced;
              cnt        <= '0;
            end else begin
              state <= ST_CHECK;
              busy  <= 1'b1;
              cnt   <= CNT_W'(1);
            end
          end else begin
            cnt <= '0;
          end
        end
        ST_CHECK: begin
          if (!differ) begin
            state <= ST_STABLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            level      <= synced;
            rise_pulse <= synced;
            fall_pulse <= !synced;
            state      <= ST_STABLE;
            busy       <= 1'b0;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_STABLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_sync.sv
// Directed, table-driven bench for debounce_sync: one instance with a 4-sample
// debounce window and one with the minimum window of 1.
module tb_debounce_sync;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a = 1'b0, din_a = 1'b0;
  logic level_a, rise_a, fall_a, busy_a;
  logic reset_b = 1'b0, din_b = 1'b0;
  logic level_b, rise_b, fall_b, busy_b;

  debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b0)) dut_a (
    .clk(clk), .reset(reset_a), .signal_async(din_a),
    .level(level_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .busy(busy_a)
  );

  debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .RESET_LEVEL(1'b0)) dut_b (
    .clk(clk), .reset(reset_b), .signal_async(din_b),
    .level(level_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .busy(busy_b)
  );

  // Vector record: inputs applied before an edge, outputs expected just after it.
  // exp packs {level, rise_pulse, fall_pulse, busy}.
  typedef struct {
    logic       sel_b;
    logic       rst;
    logic       din;
    logic [3:0] exp;
    int         phase;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;
  string      phase_names[9] = '{"reset_a", "clean_rise", "clean_fall", "short_glitch",
                                 "last_sample_glitch", "reset_mid_check",
                                 "min_rise", "min_fall", "reset_over_accept"};

  task automatic add(input logic sel_b, input int phase, input logic rst, input logic din,
                     input logic [3:0] exp);
    vec_t v;
    v.sel_b = sel_b;
    v.phase = phase;
    v.rst   = rst;
    v.din   = din;
    v.exp   = exp;
    vecs.push_back(v);
  endtask

  // Driver
  task automatic apply(input vec_t v, input int idx);
    logic [3:0] got;
    logic [3:0] want;
    if (v.sel_b) begin
      reset_b = v.rst;
      din_b   = v.din;
    end else begin
      reset_a = v.rst;
      din_a   = v.din;
    end
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    got  = v.sel_b ? {level_b, rise_b, fall_b, busy_b} : {level_a, rise_a, fall_a, busy_a};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s vec %0d: got {level,rise,fall,busy}=%b expected %b",
               phase_names[v.phase], idx, got, want);
    end
  endtask

  initial begin
    // Instance A (window 4); instance B held in reset meanwhile.
    for (int i = 0; i < 3; i++) add(1'b0, 0, 1'b0, 1'b1, 4'b0000);
    // Clean rise: busy from edge 3, level and rise at edge 6.
    add(0, 1, 1, 1, 4'b0000); add(0, 1, 1, 1, 4'b0000); add(0, 1, 1, 1, 4'b0001);
    add(0, 1, 1, 1, 4'b0001); add(0, 1, 1, 1, 4'b0001); add(0, 1, 1, 1, 4'b1100);
    add(0, 1, 1, 1, 4'b1000);
    // Clean fall
    add(0, 2, 1, 0, 4'b1000); add(0, 2, 1, 0, 4'b1000); add(0, 2, 1, 0, 4'b1001);
    add(0, 2, 1, 0, 4'b1001); add(0, 2, 1, 0, 4'b1001); add(0, 2, 1, 0, 4'b0010);
    add(0, 2, 1, 0, 4'b0000);
    // Short glitch: two high samples reach synced, then abort.
    add(0, 3, 1, 1, 4'b0000); add(0, 3, 1, 1, 4'b0000); add(0, 3, 1, 0, 4'b0001);
    add(0, 3, 1, 0, 4'b0001); add(0, 3, 1, 0, 4'b0000); add(0, 3, 1, 0, 4'b0000);
    // Last-sample glitch: cnt reaches 3, equal sample aborts, then restart from 1.
    add(0, 4, 1, 1, 4'b0000); add(0, 4, 1, 1, 4'b0000); add(0, 4, 1, 1, 4'b0001);
    add(0, 4, 1, 0, 4'b0001); add(0, 4, 1, 1, 4'b0001); add(0, 4, 1, 1, 4'b0000);
    add(0, 4, 1, 1, 4'b0001); add(0, 4, 1, 1, 4'b0001); add(0, 4, 1, 1, 4'b0001);
    add(0, 4, 1, 1, 4'b1100); add(0, 4, 1, 1, 4'b1000);
    // Reset after two differing samples aborts; idle afterwards.
    add(0, 5, 1, 0, 4'b1000); add(0, 5, 1, 0, 4'b1000); add(0, 5, 1, 0, 4'b1001);
    add(0, 5, 1, 0, 4'b1001); add(0, 5, 0, 0, 4'b0000);
    for (int i = 0; i < 4; i++) add(1'b0, 5, 1'b1, 1'b0, 4'b0000);

    // Instance B (window 1): accept at edge 3, busy never set.
    add(1, 6, 0, 0, 4'b0000); add(1, 6, 0, 0, 4'b0000);
    add(1, 6, 1, 1, 4'b0000); add(1, 6, 1, 1, 4'b0000); add(1, 6, 1, 1, 4'b1100);
    add(1, 6, 1, 1, 4'b1000);
    add(1, 7, 1, 0, 4'b1000); add(1, 7, 1, 0, 4'b1000); add(1, 7, 1, 0, 4'b0010);
    add(1, 7, 1, 0, 4'b0000);
    // Reset lands on the accept edge and wins; re-qualification after release.
    add(1, 8, 1, 1, 4'b0000); add(1, 8, 1, 1, 4'b0000); add(1, 8, 0, 1, 4'b0000);
    add(1, 8, 1, 1, 4'b0000); add(1, 8, 1, 1, 4'b0000); add(1, 8, 1, 1, 4'b1100);
    add(1, 8, 1, 1, 4'b1000);

    // Start driving just after a falling edge so the first vector meets edge 1.
    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Hand-written sequence on A: pulses must never coincide over a noisy burst.
    reset_a = 1'b1;
    for (int i = 0; i < 40; i++) begin
      din_a = 1'(i % 3 == 0);
      @(posedge clk);
      #1;
      checks++;
      if ((rise_a & fall_a) !== 1'b0) begin
        errors++;
        $display("FAIL pulse_exclusive cycle %0d: rise=%b fall=%b expected not both high",
                 i, rise_a, fall_a);
      end
    end

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
# debounce_sync

Synchronizes one asynchronous level input (pushbutton, strap, external status line) into the `clk` domain and debounces it. The block is the consumer stage of a flop-chain synchronizer. It outputs a glitch-free stable level plus single-cycle rise and fall pulses. It sits between board-level inputs and control logic that must see each physical transition exactly once.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flop depth. Legal values are ≥ 2.
- `DEBOUNCE_CYCLES`, default 1000: number of consecutive synchronized samples, all differing from `level`, required to accept a change. Legal values are ≥ 1.
- `RESET_LEVEL`, default 1'b0: value of `level` and of every synchronizer flop while in reset.
- `clk`  input  1: clock.
- `reset`  input  1: synchronous, active-low reset.
- `signal_async`  input  1: raw asynchronous input.
- `level`  output  1: debounced, registered level.
- `rise_pulse`  output  1: high for one cycle when `level` goes 0→1.
- `fall_pulse`  output  1: high for one cycle when `level` goes 1→0.
- `busy`  output  1: high while a candidate change is being qualified (FSM is in CHECK).

## Operation
- **Synchronizer:** a `SYNC_STAGES`-deep shift register clocked by `clk`. Stage 0 samples `signal_async`. `synced` is the last stage.
- **FSM states:**
  - STABLE (reset state).
  - CHECK.
- **Counter:** `cnt` is `$clog2(DEBOUNCE_CYCLES+1)` bits wide and holds the number of consecutive differing samples seen.
- **In STABLE:**
  - If `synced != level`: when `DEBOUNCE_CYCLES == 1`, accept immediately (see below) and stay in STABLE. Otherwise go to CHECK with `cnt <= 1`.
  - If `synced == level`: stay in STABLE with `cnt <= 0`.
- **In CHECK:**
  - If `synced == level` (glitch): go to STABLE with `cnt <= 0`. `level` is unchanged and no pulse fires.
  - If `synced != level` and `cnt == DEBOUNCE_CYCLES-1`: accept the change and go to STABLE.
  - Otherwise: `cnt <= cnt + 1`.
- **Accept:** `level <= synced`. On the same edge, `rise_pulse <= synced` and `fall_pulse <= !synced`. `cnt <= 0`.
- **Pulses:** `rise_pulse` and `fall_pulse` are cleared on every non-accept edge. They are never high together.
- **`busy`:** registered; equals (state == CHECK).
- **`cnt`:** never exceeds `DEBOUNCE_CYCLES-1`, so there is no wrap-around.

## Timing
- **Reset** (any edge with `reset == 0`):
  - All synchronizer flops and `level` take `RESET_LEVEL`.
  - FSM goes to STABLE with `cnt = 0`.
  - `rise_pulse`, `fall_pulse` and `busy` are 0.
  - Reset applied mid-CHECK aborts the qualification, with no pulse. Reset overrides a simultaneous accept.
- **Latency:**
  - Let edge 1 be the first edge at which a new input value is captured into stage 0.
  - `synced` shows the new value after edge `SYNC_STAGES`.
  - `level` and the pulse update at edge `SYNC_STAGES + DEBOUNCE_CYCLES`, provided the input stays constant.
  - Each pulse lasts exactly one cycle.
- **Boundary cases:**
  - A glitch on the final qualifying sample aborts; no partial accept.
  - An input that returns to `level` and then changes again restarts the count at 1.
  - After an accept, the FSM is back in STABLE. The opposite transition needs a full new `DEBOUNCE_CYCLES` of qualification.
- All outputs are registered; there are no combinational paths from any input.

## Structure
- Shared package `cdc_pkg` holds:
  - `typedef enum logic {ST_STABLE, ST_CHECK} debounce_state_t`.
  - Elaboration checks for `SYNC_STAGES >= 2` and `DEBOUNCE_CYCLES >= 1`.
- No sub-module. The synchronizer chain stays local because it must reset to `RESET_LEVEL`, so that `level` and `synced` agree immediately after reset and no spurious CHECK occurs.

## Test plan
All tests use `SYNC_STAGES = 2` and `DEBOUNCE_CYCLES = 4` unless stated.
- **Reset and clean rise:** hold `reset = 0` for 3 cycles with input 1. Expect `level = 0`, pulses 0, `busy = 0`. Release reset with input held at 1. Expect `busy` high after edge 3 and `level = 1` after edge 6. `rise_pulse` is high only in the cycle after edge 6.
- **Short glitch:** input 1 for 3 edges, then 0. Expect `busy` to pulse. `level` stays 0 and there are no pulses.
- **Last-sample glitch:** input sequence produces 3 differing synced samples, then 1 equal sample. Expect abort, `level = 0`, no pulse. A following steady 1 accepts 4 samples later.
- **Clean fall:** with `level = 1`, drive input 0 steady. Expect `level = 0` at edge 6 and exactly one `fall_pulse`.
- **Reset mid-CHECK:** assert reset after 2 differing samples. Next edge: `busy = 0`, `level = 0`, no pulse. Release reset with input 0. Expect no activity.
- **Minimum debounce:** with `DEBOUNCE_CYCLES = 1`, a steady input change gives `level` at edge 3 and `busy` never asserts.
